fetch_queue_stage: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline latch.
- Owns the PC, issues reads to the icache and buffers returned words in a small prefetch queue.
- Drives the IF/ID front inputs (imemload_IFID, PC4_IFID) and the synchronous ifidKill.
- Redirects from EX/MEM flush the queue; a halt freezes fetch permanently until reset.

---
 rtl/fetch_queue_stage_if.sv | 29 ++
 rtl/fetch_queue_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - icache, IF/ID and perf signal bundle of the fetch stage
interface fetch_queue_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ppEN;
  logic        bubble;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imemload_IFID;
  logic [31:0] PC4_IFID;
  logic        ifidKill;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    input  ihit, imemload, ppEN, bubble, redirect, redirect_pc, halt,
    output imemREN, imemaddr, imemload_IFID, PC4_IFID, ifidKill,
           perf_fetch_cnt, perf_stall_cnt
  );

  modport slave (
    output ihit, imemload, ppEN, bubble, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, imemload_IFID, PC4_IFID, ifidKill,
           perf_fetch_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - PC, icache request and prefetch queue feeding the IF/ID latch
// Optional fetch/stall performance counters are built only when FETCH_PERF_EN is defined.
module fetch_queue_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter int          QDEPTH  = 2
) (
  input logic                 CLK,
  input logic                 nRST,
  fetch_queue_stage_if.master fq
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] RESTART = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc4   [QDEPTH];

  logic empty;
  logic pop;
  logic ren;
  logic push;

  assign empty = (count == '0);
  assign pop   = fq.ppEN & ~fq.bubble & ~empty & ~fq.redirect & (state != HALTED);
  // Gated by nRST so the icache sees no request while reset is held.
  assign ren   = nRST & (state == FETCH) & ~fq.redirect & ~fq.halt &
                 ((count < CW'(QDEPTH)) | pop);
  assign push  = ren & fq.ihit;

  assign fq.imemREN       = ren;
  assign fq.imemaddr      = pc;
  assign fq.imemload_IFID = empty ? 32'h0 : q_instr[rd_ptr];
  assign fq.PC4_IFID      = empty ? 32'haaaaaaaa : q_pc4[rd_ptr];
  assign fq.ifidKill      = fq.redirect | empty | (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      pc     <= PC_INIT;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (fq.halt) begin
      state  <= HALTED;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (state != HALTED) begin
      if (fq.redirect) begin
        state  <= RESTART;
        pc     <= fq.redirect_pc;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        state <= FETCH;
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_instr[wr_ptr] <= fq.imemload;
      q_pc4[wr_ptr]   <= pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != 32'hFFFFFFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (ren && !fq.ihit && (stall_cnt != 32'hFFFFFFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign fq.perf_fetch_cnt = fetch_cnt;
  assign fq.perf_stall_cnt = stall_cnt;
`else
  assign fq.perf_fetch_cnt = 32'h0;
  assign fq.perf_stall_cnt = 32'h0;
`endif
endmodule
